// File: rtl/bram_buf_writer.sv
// Sequential BRAM buffer filler: accepts words while filling, writes them one cycle later,
// holds off upstream once C_DEPTH words are captured until the consumer releases the buffer.
module bram_buf_writer #(
  parameter int C_DATA_WIDTH = 32,
  parameter int C_ADDR_WIDTH = 10,
  parameter int C_DEPTH      = 1024
) (
  input  logic                      BUF_ACLK,
  input  logic                      BUF_ARESET,
  input  logic [C_DATA_WIDTH-1:0]   DIN,
  input  logic                      DIN_VALID,
  output logic                      DIN_ACCEP,
  output logic [C_ADDR_WIDTH-1:0]   BRAM_ADDR,
  output logic [C_DATA_WIDTH-1:0]   BRAM_DIN,
  output logic                      BRAM_EN,
  output logic [C_DATA_WIDTH/8-1:0] BRAM_WE,
  output logic                      BUF_FULL,
  output logic                      BUF_DONE,
  input  logic                      BUF_RELEASE,
  output logic [C_ADDR_WIDTH:0]     BUF_COUNT
);

  typedef enum logic {FILL, HOLD} state_t;

  localparam logic [C_ADDR_WIDTH:0] DEPTH_C = (C_ADDR_WIDTH+1)'(C_DEPTH);
  localparam logic [C_ADDR_WIDTH:0] ONE_C   = (C_ADDR_WIDTH+1)'(1);

  state_t                    state_q, state_d;
  logic                      accep_q, accep_d;
  logic [C_ADDR_WIDTH:0]     count_q, count_d;
  logic [C_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [C_DATA_WIDTH-1:0]   dat_q, dat_d;
  logic                      en_q, en_d;
  logic                      full_q, full_d;
  logic                      done_q, done_d;
  logic                      last_q, last_d;
  logic                      xfer;
  logic                      release_ok;

  assign xfer       = DIN_VALID & accep_q;
  assign release_ok = BUF_RELEASE & full_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    addr_d  = addr_q;
    dat_d   = dat_q;
    en_d    = xfer;
    last_d  = 1'b0;
    // last_q marks the cycle the final word sits on the BRAM port; full follows its write edge
    done_d  = last_q;
    full_d  = full_q | last_q;

    if (xfer) begin
      addr_d  = count_q[C_ADDR_WIDTH-1:0];
      dat_d   = DIN;
      count_d = count_q + ONE_C;
    end

    case (state_q)
      FILL: begin
        if (xfer && (count_q == DEPTH_C - ONE_C)) begin
          state_d = HOLD;
          last_d  = 1'b1;
        end
      end
      HOLD: begin
        if (release_ok) begin
          state_d = FILL;
          count_d = '0;
          full_d  = 1'b0;
        end
      end
      default: state_d = FILL;
    endcase

    // Registered from next state so accept never depends combinationally on inputs
    accep_d = (state_d == FILL);
  end

  always_ff @(posedge BUF_ACLK) begin
    if (BUF_ARESET) begin
      state_q <= FILL;
      accep_q <= 1'b0;
      count_q <= '0;
      addr_q  <= '0;
      dat_q   <= '0;
      en_q    <= 1'b0;
      full_q  <= 1'b0;
      done_q  <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      accep_q <= accep_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      dat_q   <= dat_d;
      en_q    <= en_d;
      full_q  <= full_d;
      done_q  <= done_d;
      last_q  <= last_d;
    end
  end

  assign DIN_ACCEP = accep_q;
  assign BRAM_ADDR = addr_q;
  assign BRAM_DIN  = dat_q;
  assign BRAM_EN   = en_q;
  assign BRAM_WE   = {(C_DATA_WIDTH/8){en_q}};
  assign BUF_FULL  = full_q;
  assign BUF_DONE  = done_q;
  assign BUF_COUNT = count_q;

endmodule

// File: tb/tb_bram_buf_writer.sv
// Bench for bram_buf_writer: depth-4 and depth-1 instances in lockstep against a
// transaction-level reference model plus a bench-side BRAM image.
module tb_bram_buf_writer;

  logic        clk;
  logic        rst [2];
  logic        vld [2];
  logic        rel [2];
  logic [31:0] din [2];

  logic        acc_w  [2];
  logic [9:0]  addr_w [2];
  logic [31:0] dat_w  [2];
  logic        en_w   [2];
  logic [3:0]  we_w   [2];
  logic        full_w [2];
  logic        done_w [2];
  logic [10:0] cnt_w  [2];

  int n_cmp = 0;
  int n_err = 0;

  int          dep    [2];
  int          m_cnt  [2];
  bit          m_acc  [2];
  bit          m_en   [2];
  int          m_addr [2];
  logic [31:0] m_dat  [2];
  bit          m_full [2];
  bit          m_done [2];
  bit          m_last [2];
  logic [31:0] em  [2][4];
  logic [31:0] mem [2][4];

  bram_buf_writer #(.C_DATA_WIDTH(32), .C_ADDR_WIDTH(10), .C_DEPTH(4)) u_d4 (
    .BUF_ACLK(clk), .BUF_ARESET(rst[0]), .DIN(din[0]), .DIN_VALID(vld[0]),
    .DIN_ACCEP(acc_w[0]), .BRAM_ADDR(addr_w[0]), .BRAM_DIN(dat_w[0]),
    .BRAM_EN(en_w[0]), .BRAM_WE(we_w[0]), .BUF_FULL(full_w[0]),
    .BUF_DONE(done_w[0]), .BUF_RELEASE(rel[0]), .BUF_COUNT(cnt_w[0]));

  bram_buf_writer #(.C_DATA_WIDTH(32), .C_ADDR_WIDTH(10), .C_DEPTH(1)) u_d1 (
    .BUF_ACLK(clk), .BUF_ARESET(rst[1]), .DIN(din[1]), .DIN_VALID(vld[1]),
    .DIN_ACCEP(acc_w[1]), .BRAM_ADDR(addr_w[1]), .BRAM_DIN(dat_w[1]),
    .BRAM_EN(en_w[1]), .BRAM_WE(we_w[1]), .BUF_FULL(full_w[1]),
    .BUF_DONE(done_w[1]), .BUF_RELEASE(rel[1]), .BUF_COUNT(cnt_w[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench-side BRAM: captures whatever the write port presents at each edge
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      if (en_w[i] && we_w[i] == 4'hF && addr_w[i] < 10'd4)
        mem[i][addr_w[i][1:0]] <= dat_w[i];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Buffer abstraction: accepting means fewer than depth words are in the current fill
  task automatic model_edge(input int i);
    bit xfer, relz;
    if (rst[i]) begin
      m_cnt[i] = 0; m_acc[i] = 0; m_en[i] = 0; m_addr[i] = 0; m_dat[i] = 0;
      m_full[i] = 0; m_done[i] = 0; m_last[i] = 0;
    end else begin
      xfer = vld[i] && m_acc[i];
      relz = rel[i] && m_full[i];
      m_done[i] = m_last[i];
      if (relz) m_full[i] = 0;
      else if (m_last[i]) m_full[i] = 1;
      m_en[i] = xfer;
      if (xfer) begin
        m_addr[i] = m_cnt[i];
        m_dat[i]  = din[i];
        em[i][m_cnt[i]] = din[i];
      end
      m_last[i] = xfer && (m_cnt[i] + 1 == dep[i]);
      if (relz) m_cnt[i] = 0;
      else if (xfer) m_cnt[i] = m_cnt[i] + 1;
      m_acc[i] = (m_cnt[i] < dep[i]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_edge(i);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("accep%0d", i), 64'(acc_w[i]), 64'(m_acc[i]));
      chk($sformatf("count%0d", i), 64'(cnt_w[i]), 64'(m_cnt[i]));
      chk($sformatf("en%0d", i),    64'(en_w[i]),  64'(m_en[i]));
      chk($sformatf("we%0d", i),    64'(we_w[i]),  m_en[i] ? 64'hF : 64'h0);
      chk($sformatf("addr%0d", i),  64'(addr_w[i]), 64'(m_addr[i]));
      chk($sformatf("data%0d", i),  64'(dat_w[i]), 64'(m_dat[i]));
      chk($sformatf("full%0d", i),  64'(full_w[i]), 64'(m_full[i]));
      chk($sformatf("done%0d", i),  64'(done_w[i]), 64'(m_done[i]));
      if (m_done[i])
        for (int a = 0; a < dep[i]; a++)
          chk($sformatf("mem%0d_%0d", i, a), 64'(mem[i][a]), 64'(em[i][a]));
    end
  endtask

  initial begin
    dep[0] = 4; dep[1] = 1;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1; vld[i] = 0; rel[i] = 0; din[i] = '0;
      for (int a = 0; a < 4; a++) begin em[i][a] = '0; mem[i][a] = '0; end
    end
    step(); step();
    chk("rst_accep", 64'(acc_w[0]), 64'd0);
    chk("rst_count", 64'(cnt_w[0]), 64'd0);
    rst[0] = 0; rst[1] = 0;
    step();
    chk("accep_after_rst", 64'(acc_w[0]), 64'd1);

    // Back-to-back fill of four words
    for (int w = 0; w < 4; w++) begin
      vld[0] = 1; din[0] = 32'(w);
      step();
    end
    chk("fill_accep_low", 64'(acc_w[0]), 64'd0);
    chk("fill_last_addr", 64'(addr_w[0]), 64'd3);
    chk("fill_full_not_yet", 64'(full_w[0]), 64'd0);
    din[0] = 32'd4;
    step();
    chk("full_rise", 64'(full_w[0]), 64'd1);
    chk("done_pulse", 64'(done_w[0]), 64'd1);
    step();
    chk("done_clear", 64'(done_w[0]), 64'd0);
    for (int c = 0; c < 3; c++) step();
    chk("hold_count", 64'(cnt_w[0]), 64'd4);
    chk("hold_no_write", 64'(en_w[0]), 64'd0);

    rel[0] = 1; step(); rel[0] = 0;
    chk("rel_accep", 64'(acc_w[0]), 64'd1);
    chk("rel_full", 64'(full_w[0]), 64'd0);
    step();
    chk("post_rel_addr", 64'(addr_w[0]), 64'd0);
    chk("post_rel_data", 64'(dat_w[0]), 64'd4);
    chk("post_rel_count", 64'(cnt_w[0]), 64'd1);

    // Reset while the write of address 1 is pending
    din[0] = 32'd5; step();
    vld[0] = 0; rst[0] = 1; step();
    chk("rst_mid_we", 64'(we_w[0]), 64'd0);
    chk("rst_mid_count", 64'(cnt_w[0]), 64'd0);
    rst[0] = 0; vld[0] = 1; din[0] = 32'd6;
    step(); step();
    chk("after_rst_addr", 64'(addr_w[0]), 64'd0);
    chk("after_rst_data", 64'(dat_w[0]), 64'd6);
    vld[0] = 0;

    // Depth-1 instance: single word fills
    vld[1] = 1; din[1] = 32'h9; step();
    vld[1] = 0;
    chk("d1_accep_low", 64'(acc_w[1]), 64'd0);
    step();
    chk("d1_full", 64'(full_w[1]), 64'd1);
    chk("d1_done", 64'(done_w[1]), 64'd1);
    rel[1] = 1; step(); rel[1] = 0;
    chk("d1_rel_accep", 64'(acc_w[1]), 64'd1);

    // Randomized traffic, releases and occasional resets
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < 2; i++) begin
        vld[i] = ($urandom_range(0, 9) < 7);
        din[i] = $urandom;
        rel[i] = ($urandom_range(0, 9) < 3);
        rst[i] = ($urandom_range(0, 199) == 0);
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
